// File: rtl/mul_err_stats_if.sv
// Exact/approximate product pair stream from the multiplier stage.
interface mul_err_stats_if #(
    parameter int unsigned PW = 17
);
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] exact;
    logic [PW-1:0] approx;

    modport master (output in_valid, exact, approx, input in_ready);
    modport slave  (input in_valid, exact, approx, output in_ready);
endinterface

// File: rtl/mul_err_stats.sv
// Error statistics over a programmed number of exact/approximate product pairs:
// error count, saturating sum of error distance and maximum error distance.
module mul_err_stats #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PW    = 2 * WIDTH + 1,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned ACC_W = 40
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_samples,
    mul_err_stats_if.slave       pin,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     sample_count,
    output logic [CNT_W-1:0]     err_count,
    output logic [ACC_W-1:0]     sum_ed,
    output logic [PW-1:0]        max_ed,
    output logic                 sum_sat
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] remaining_q;
    logic [CNT_W-1:0] sample_count_q, err_count_q;
    logic [ACC_W-1:0] sum_q;
    logic [PW-1:0]    max_q;
    logic             sat_q;
    logic [PW-1:0]    ed_q, ed_d;
    logic             nz_q;
    logic             v1_q;
    logic             done_q, busy_q;
    logic             hs;
    logic             clear;
    logic [ACC_W:0]   sum_ext;

    assign hs = pin.in_valid & (state_q == S_RUN);

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !done_q) begin
                    clear   = 1'b1;
                    state_d = (num_samples != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (hs && remaining_q == CNT_W'(1)) state_d = S_DRAIN;
            end
            // Stage 2 is the accumulator itself, so once v1 is clear the stats are final.
            S_DRAIN: begin
                if (!v1_q) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ed_d = (pin.exact >= pin.approx) ? (pin.exact - pin.approx)
                                         : (pin.approx - pin.exact);
        sum_ext = {1'b0, sum_q} + {{(ACC_W + 1 - PW){1'b0}}, ed_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            remaining_q    <= '0;
            sample_count_q <= '0;
            err_count_q    <= '0;
            sum_q          <= '0;
            max_q          <= '0;
            sat_q          <= 1'b0;
            ed_q           <= '0;
            nz_q           <= 1'b0;
            v1_q           <= 1'b0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            // done and busy trail the DONE state by one cycle so busy covers the done pulse.
            done_q  <= (state_q == S_DONE);
            busy_q  <= (state_d != S_IDLE) || (state_q == S_DONE);

            v1_q <= hs;
            if (hs) begin
                ed_q <= ed_d;
                nz_q <= (ed_d != '0);
            end

            if (clear) begin
                remaining_q    <= num_samples;
                sample_count_q <= '0;
            end else if (hs) begin
                remaining_q    <= remaining_q - CNT_W'(1);
                sample_count_q <= sample_count_q + CNT_W'(1);
            end

            if (clear) begin
                err_count_q <= '0;
                sum_q       <= '0;
                max_q       <= '0;
                sat_q       <= 1'b0;
            end else if (v1_q) begin
                err_count_q <= err_count_q + {{(CNT_W - 1){1'b0}}, nz_q};
                if (sum_ext[ACC_W]) begin
                    sum_q <= '1;
                    sat_q <= 1'b1;
                end else begin
                    sum_q <= sum_ext[ACC_W-1:0];
                end
                if (ed_q > max_q) max_q <= ed_q;
            end
        end
    end

    assign pin.in_ready  = (state_q == S_RUN);
    assign busy          = busy_q;
    assign done          = done_q;
    assign sample_count  = sample_count_q;
    assign err_count     = err_count_q;
    assign sum_ed        = sum_q;
    assign max_ed        = max_q;
    assign sum_sat       = sat_q;

endmodule

// File: tb/tb_mul_err_stats.sv
// Directed bench for mul_err_stats: a 40-bit accumulator instance and a 17-bit one for saturation.
module tb_mul_err_stats;

    localparam int unsigned PW = 17;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start0 = 1'b0, start1 = 1'b0;
    logic [15:0] num0 = '0, num1 = '0;
    logic        busy0, done0, sat0, busy1, done1, sat1;
    logic [15:0] cnt0, err0, cnt1, err1;
    logic [39:0] sum0;
    logic [16:0] sum1;
    logic [PW-1:0] max0, max1;

    mul_err_stats_if #(.PW(PW)) if0 ();
    mul_err_stats_if #(.PW(PW)) if1 ();

    mul_err_stats #(.WIDTH(8), .ACC_W(40)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .num_samples(num0), .pin(if0),
        .busy(busy0), .done(done0), .sample_count(cnt0), .err_count(err0),
        .sum_ed(sum0), .max_ed(max0), .sum_sat(sat0));

    mul_err_stats #(.WIDTH(8), .ACC_W(17)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .num_samples(num1), .pin(if1),
        .busy(busy1), .done(done1), .sample_count(cnt1), .err_count(err1),
        .sum_ed(sum1), .max_ed(max1), .sum_sat(sat1));

    int n_checks = 0;
    int n_fail   = 0;
    int pulses0  = 0;
    int pulses1  = 0;

    longint unsigned qe[$], qa[$];
    longint unsigned e0_cnt, e0_err, e0_sum, e0_max, e1_cnt, e1_err, e1_sum, e1_max;
    bit              e0_sat, e1_sat;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Statistics straight from the definition over the pairs in qe/qa.
    function automatic void model(input int accw, output longint unsigned cnt, output longint unsigned err,
                                  output longint unsigned sum, output longint unsigned mx, output bit sat);
        longint unsigned lim, d;
        lim = (64'd1 << accw) - 1;
        cnt = 0; err = 0; sum = 0; mx = 0; sat = 0;
        foreach (qe[i]) begin
            d = (qe[i] >= qa[i]) ? qe[i] - qa[i] : qa[i] - qe[i];
            cnt++;
            if (d != 0) err++;
            sum += d;
            if (sum > lim) begin
                sum = lim;
                sat = 1;
            end
            if (d > mx) mx = d;
        end
    endfunction

    always @(negedge clk) begin
        if (done0) begin
            pulses0++;
            chk("u0_sample_count", cnt0, e0_cnt);
            chk("u0_err_count", err0, e0_err);
            chk("u0_sum_ed", sum0, e0_sum);
            chk("u0_max_ed", max0, e0_max);
            chk("u0_sum_sat", sat0, e0_sat);
            chk("u0_busy_in_done", busy0, 1);
        end
        if (done1) begin
            pulses1++;
            chk("u1_sample_count", cnt1, e1_cnt);
            chk("u1_err_count", err1, e1_err);
            chk("u1_sum_ed", sum1, e1_sum);
            chk("u1_max_ed", max1, e1_max);
            chk("u1_sum_sat", sat1, e1_sat);
        end
    end

    task automatic start_u0(input logic [15:0] n);
        @(negedge clk);
        start0 = 1'b1;
        num0 = n;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        num0 = '0;
    endtask

    task automatic send_u0(input longint unsigned e, input longint unsigned a);
        int b;
        if0.in_valid = 1'b1;
        if0.exact = PW'(e);
        if0.approx = PW'(a);
        b = 0;
        while (!if0.in_ready && b < 50) begin
            @(posedge clk);
            #1;
            b++;
        end
        if (b == 50) chk("u0_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        if0.in_valid = 1'b0;
    endtask

    task automatic send_u1(input longint unsigned e, input longint unsigned a);
        int b;
        if1.in_valid = 1'b1;
        if1.exact = PW'(e);
        if1.approx = PW'(a);
        b = 0;
        while (!if1.in_ready && b < 50) begin
            @(posedge clk);
            #1;
            b++;
        end
        if (b == 50) chk("u1_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        if1.in_valid = 1'b0;
    endtask

    // Called just after the final handshake edge: done is due in the cycle after the 3rd edge.
    task automatic tail_u0(input string tag);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk({tag, "_done_timing"}, done0, (k == 3));
            if (k < 3) chk({tag, "_ready_low"}, if0.in_ready, 0);
            if (k == 4) chk({tag, "_busy_after"}, busy0, 0);
        end
    endtask

    task automatic set_exp0();
        model(40, e0_cnt, e0_err, e0_sum, e0_max, e0_sat);
    endtask

    initial begin
        int p;
        int gaps[4] = '{0, 2, 1, 3};
        longint unsigned t1e[4] = '{100, 200, 50, 0};
        longint unsigned t1a[4] = '{100, 196, 60, 0};
        if0.in_valid = 1'b0; if0.exact = '0; if0.approx = '0;
        if1.in_valid = 1'b0; if1.exact = '0; if1.approx = '0;

        #12;
        chk("reset_busy", busy0, 0);
        chk("reset_done", done0, 0);
        chk("reset_ready", if0.in_ready, 0);
        chk("reset_sum", sum0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: back-to-back pairs
        qe.delete(); qa.delete();
        for (int i = 0; i < 4; i++) begin qe.push_back(t1e[i]); qa.push_back(t1a[i]); end
        set_exp0();
        chk("model_err", e0_err, 2);
        chk("model_sum", e0_sum, 14);
        chk("model_max", e0_max, 10);
        start_u0(16'd4);
        for (int i = 0; i < 4; i++) send_u0(t1e[i], t1a[i]);
        tail_u0("t1");

        // 2: same pairs with idle gaps
        start_u0(16'd4);
        for (int i = 0; i < 4; i++) begin
            send_u0(t1e[i], t1a[i]);
            if (i < 3) begin
                for (int g = 0; g < gaps[i]; g++) begin
                    @(posedge clk);
                    #1;
                    chk("t2_ready_run", if0.in_ready, 1);
                end
            end
        end
        tail_u0("t2");

        // 3: zero samples
        qe.delete(); qa.delete();
        set_exp0();
        start_u0(16'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_done", done0, (k == 1));
            chk("t3_busy", busy0, (k < 2));
            chk("t3_ready", if0.in_ready, 0);
        end

        // 4: saturation on the 17-bit accumulator, then clear on next start
        qe.delete(); qa.delete();
        qe.push_back(64'h1FFFF); qa.push_back(0);
        qe.push_back(64'h1FFFF); qa.push_back(0);
        model(17, e1_cnt, e1_err, e1_sum, e1_max, e1_sat);
        chk("model_sat", e1_sat, 1);
        chk("model_sum_clamp", e1_sum, 64'h1FFFF);
        @(negedge clk); start1 = 1'b1; num1 = 16'd2;
        @(posedge clk); #1; start1 = 1'b0;
        send_u1(64'h1FFFF, 0);
        send_u1(64'h1FFFF, 0);
        repeat (5) @(negedge clk);
        chk("t4_pulses", pulses1, 1);
        qe.delete(); qa.delete();
        qe.push_back(5); qa.push_back(5);
        model(17, e1_cnt, e1_err, e1_sum, e1_max, e1_sat);
        @(negedge clk); start1 = 1'b1; num1 = 16'd1;
        @(posedge clk); #1; start1 = 1'b0;
        chk("t4_sat_cleared", sat1, 0);
        chk("t4_sum_cleared", sum1, 0);
        send_u1(5, 5);
        repeat (5) @(negedge clk);
        chk("t4_pulses2", pulses1, 2);

        // 5: asynchronous reset mid-run
        start_u0(16'd5);
        send_u0(9, 1);
        send_u0(4, 8);
        p = pulses0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_cnt", cnt0, 0);
        chk("t5_err", err0, 0);
        chk("t5_sum", sum0, 0);
        chk("t5_max", max0, 0);
        chk("t5_busy", busy0, 0);
        chk("t5_ready", if0.in_ready, 0);
        repeat (4) @(negedge clk);
        chk("t5_no_done", pulses0, p);
        rst_n = 1'b1;
        qe.delete(); qa.delete();
        qe.push_back(7); qa.push_back(3);
        set_exp0();
        chk("model_t5_sum", e0_sum, 4);
        start_u0(16'd1);
        send_u0(7, 3);
        tail_u0("t5");

        // 6: start during RUN is ignored
        qe.delete(); qa.delete();
        qe.push_back(10); qa.push_back(10);
        qe.push_back(20); qa.push_back(21);
        qe.push_back(30); qa.push_back(27);
        set_exp0();
        start_u0(16'd3);
        send_u0(10, 10);
        @(negedge clk); start0 = 1'b1; num0 = 16'd9;
        @(posedge clk); #1; start0 = 1'b0; num0 = '0;
        chk("t6_ready_still", if0.in_ready, 1);
        send_u0(20, 21);
        send_u0(30, 27);
        tail_u0("t6");
        chk("t6_cnt_final", cnt0, 3);

        chk("u0_total_pulses", pulses0, 5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/mul_err_stats.md
Name: mul_err_stats

Overview:
- Downstream consumer of the multiplier stage.
- Receives product pairs: the exact `dadda_*` product and the approximate `approx*_dadda_*` product for the same operands.
- Accumulates error statistics over a programmed number of samples: error count, sum of error distance, and maximum error distance.
- Used to characterise each approximate Dadda configuration in simulation and on FPGA.

Parameters:
- WIDTH, 8: multiplier operand width.
- PW, 2*WIDTH+1: product width, matching the multiplier interface output width.
- CNT_W, 16: width of the sample counter and the error counter.
- ACC_W, 40: width of the error-distance accumulator.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: begin a measurement run; sampled only in IDLE.
- num_samples, input, CNT_W: samples per run; captured on start.
- in_valid, input, 1: exact/approx pair valid.
- in_ready, output, 1: block accepts a pair.
- exact, input, PW: exact product.
- approx, input, PW: approximate product.
- busy, output, 1: state is not IDLE.
- done, output, 1: one-cycle pulse; statistics final.
- sample_count, output, CNT_W: pairs accepted this run.
- err_count, output, CNT_W: pairs with exact != approx.
- sum_ed, output, ACC_W: saturating sum of |exact - approx|.
- max_ed, output, PW: maximum |exact - approx|.
- sum_sat, output, 1: sticky flag; sum_ed saturated this run.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, including in_ready, busy, done and every statistic; pipeline valid bits cleared. Reset mid-run abandons the run; no done pulse.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready=0.
  - start=1 and num_samples!=0: clear all statistics, load remaining=num_samples, go to RUN.
  - start=1 and num_samples==0: clear statistics, go to DONE.
- RUN:
  - in_ready=1 every cycle; in_valid gaps are legal.
  - Handshake = in_valid & in_ready at a rising edge. On a handshake: sample_count+1, remaining-1.
  - Handshake with remaining==1: go to DRAIN; in_ready low from the next cycle.
- DRAIN:
  - in_ready=0.
  - Go to DONE once both pipeline valid bits are 0.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - Statistics hold until the next accepted start.
- start outside IDLE is ignored; num_samples is not re-captured.
- Pipeline stage 1 (registered at handshake edge):
  - ed = |exact - approx|, computed as unsigned and fitting in PW bits.
  - nz = (ed != 0).
  - v1 = 1.
- Pipeline stage 2 (next edge, when v1):
  - sum_ed = min(sum_ed + ed, 2^ACC_W - 1); sum_sat set if clamped, sticky until the next start.
  - err_count += nz; err_count does not wrap, since it is bounded by num_samples.
  - max_ed = max(max_ed, ed).
- Back-to-back handshakes are supported every cycle; throughput is 1 pair per cycle.
- Latency: done is high in the cycle after the 3rd rising edge following the final handshake edge.
  - Edge 2: the DRAIN→DONE transition is taken.
  - Edge 3: state is DONE; done is visible in the following cycle.
  - Statistics are final from edge 2 onward.
- busy = (state != IDLE); busy is high during the done cycle.
- Outputs are driven directly from registers; no combinational path from the inputs to any output except none (in_ready is state-decoded).

Test Plan:
1. WIDTH=8. start, num_samples=4. Pairs (exact, approx) = (100,100), (200,196), (50,60), (0,0), sent back-to-back.
   - Required: sample_count=4, err_count=2, sum_ed=14, max_ed=10, sum_sat=0.
   - done high for exactly 1 cycle; busy low in the cycle after done.
2. Same four pairs with 0–3 idle cycles of in_valid=0 between them.
   - Required: identical statistics; in_ready=1 throughout RUN; no sample lost or double-counted.
3. start with num_samples=0.
   - Required: done pulses 1 cycle after the start edge's next edge; all statistics 0; in_ready never rises.
4. ACC_W=17, num_samples=2, pairs (0x1FFFF,0) twice.
   - Required: sum_ed=0x1FFFF, sum_sat=1, max_ed=0x1FFFF, err_count=2.
   - A subsequent start clears sum_sat to 0.
5. num_samples=5; assert rst_n=0 asynchronously after 2 handshakes.
   - Required: all outputs 0 immediately, no done pulse.
   - After release, a fresh run with 1 pair (7,3) gives sum_ed=4, err_count=1.
6. During RUN of a num_samples=3 run, pulse start with num_samples=9.
   - Required: ignored; run completes after exactly 3 handshakes with sample_count=3.
